// File: rtl/byte_lane_arbiter_4f_pkg.sv
// Shared encodings, output bundle and lane arithmetic for the byte-lane arbiter.
package byte_lane_arbiter_4f_pkg;

  localparam int LANE_W         = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    lane_t      lane;
    logic       first;
    logic       last;
    logic       abort;
  } out_t;

  function automatic lane_t lane_inc(input lane_t lane, input int nlanes);
    return (int'(lane) == nlanes - 1) ? '0 : lane + lane_t'(1);
  endfunction

endpackage

// File: rtl/byte_lane_arbiter_4f_if.sv
// Lane-side request bus and packer-side byte stream of the byte-lane arbiter.
interface byte_lane_arbiter_4f_if #(parameter int NLANES = 4);
  import byte_lane_arbiter_4f_pkg::*;

  logic [NLANES-1:0]   valid_in;
  logic [8*NLANES-1:0] data_in;
  logic [NLANES-1:0]   ready_out;
  logic                valid_out;
  logic [7:0]          data_out;
  lane_t               lane_out;
  logic                first_out;
  logic                last_out;
  logic                abort_out;

  modport master (
    output valid_in, data_in,
    input  ready_out, valid_out, data_out, lane_out, first_out, last_out, abort_out
  );

  modport slave (
    input  valid_in, data_in,
    output ready_out, valid_out, data_out, lane_out, first_out, last_out, abort_out
  );

endinterface

// File: rtl/byte_lane_arbiter_4f_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after ptr, modulo NLANES.
module byte_lane_arbiter_4f_rr_pick
  import byte_lane_arbiter_4f_pkg::*;
#(
  parameter int NLANES = 4
) (
  input  logic [NLANES-1:0] req_i,
  input  lane_t             ptr_i,
  output lane_t             gnt_idx_o,
  output logic              any_req_o
);

  lane_t cand [NLANES];

  for (genvar k = 0; k < NLANES; k++) begin : g_cand
    assign cand[k] = lane_t'((int'(ptr_i) + k) % NLANES);
  end

  // Scan from the farthest candidate back toward ptr so the nearest request wins.
  always_comb begin
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    for (int k = NLANES - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        gnt_idx_o = cand[k];
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_lane_arbiter_4f.sv
// Grants one lane per 4-byte word round-robin, forwards its bytes with first/last/lane tags,
// and aborts a word after TIMEOUT consecutive stalled cycles.
module byte_lane_arbiter_4f
  import byte_lane_arbiter_4f_pkg::*;
#(
  parameter int NLANES  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  byte_lane_arbiter_4f_if.slave bus
);

  logic [0:0] state_q, state_d;
  lane_t      grant_q, grant_d;
  lane_t      ptr_q, ptr_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [7:0] icnt_q, icnt_d;
  out_t       out_q, out_d;

  lane_t      pick_idx;
  logic       any_req;
  logic       in_burst;
  logic       xfer;
  logic [7:0] lane_byte [NLANES];

  byte_lane_arbiter_4f_rr_pick #(.NLANES(NLANES)) u_rr_pick (
    .req_i     (bus.valid_in),
    .ptr_i     (ptr_q),
    .gnt_idx_o (pick_idx),
    .any_req_o (any_req)
  );

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign lane_byte[i] = bus.data_in[8*i +: 8];
  end

  assign in_burst      = (state_q == ST_BURST);
  assign bus.ready_out = in_burst ? (NLANES'(1) << grant_q) : '0;
  assign xfer          = in_burst && bus.valid_in[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    icnt_d  = icnt_q;
    out_d   = '0;

    if (!in_burst) begin
      if (any_req) begin
        grant_d = pick_idx;
        bcnt_d  = '0;
        icnt_d  = '0;
        state_d = ST_BURST;
      end
    end else if (xfer) begin
      out_d.vld   = 1'b1;
      out_d.dat   = lane_byte[grant_q];
      out_d.lane  = grant_q;
      out_d.first = (bcnt_q == 2'd0);
      out_d.last  = (bcnt_q == 2'(BYTES_PER_WORD - 1));
      bcnt_d      = bcnt_q + 2'd1;
      icnt_d      = '0;
      if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
        state_d = ST_IDLE;
        ptr_d   = lane_inc(grant_q, NLANES);
      end
    end else if (icnt_q == 8'(TIMEOUT - 1)) begin
      // Source went quiet too long: drop the word and move the pointer past it.
      out_d.abort = 1'b1;
      icnt_d      = '0;
      state_d     = ST_IDLE;
      ptr_d       = lane_inc(grant_q, NLANES);
    end else begin
      icnt_d = icnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      icnt_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      icnt_q  <= icnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.valid_out = out_q.vld;
  assign bus.data_out  = out_q.dat;
  assign bus.lane_out  = out_q.lane;
  assign bus.first_out = out_q.first;
  assign bus.last_out  = out_q.last;
  assign bus.abort_out = out_q.abort;

endmodule

// File: tb/tb_byte_lane_arbiter_4f.sv
// Bench for byte_lane_arbiter_4f: a 4-lane and a 3-lane instance against a word-level reference model.
module tb_byte_lane_arbiter_4f;

  localparam int NA = 4;
  localparam int TA = 15;
  localparam int NB = 3;
  localparam int TB = 4;

  logic clk_4f = 1'b0;
  logic reset;
  always #5 clk_4f = ~clk_4f;

  byte_lane_arbiter_4f_if #(.NLANES(NA)) bus_a ();
  byte_lane_arbiter_4f_if #(.NLANES(NB)) bus_b ();

  byte_lane_arbiter_4f #(.NLANES(NA), .TIMEOUT(TA)) dut_a (.clk_4f(clk_4f), .reset(reset), .bus(bus_a));
  byte_lane_arbiter_4f #(.NLANES(NB), .TIMEOUT(TB)) dut_b (.clk_4f(clk_4f), .reset(reset), .bus(bus_b));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int nl[2] = '{NA, NB};
  int to[2] = '{TA, TB};

  // Reference model: owner = -1 means nobody holds a word.
  int owner[2], start[2], count[2], stall[2];
  bit e_vld[2], e_first[2], e_last[2], e_abort[2];
  int e_lane[2];
  logic [7:0] e_dat[2];

  // Lane sources
  logic [7:0] src_q[2][4][$];
  bit held[2][4];
  int pct[2];
  bit v_in[2][4];
  logic [7:0] d_in[2][4];

  // Observations
  bit o_vld[2], o_first[2], o_last[2], o_abort[2];
  int o_lane[2], o_rdy[2];
  logic [7:0] o_dat[2];
  logic [31:0] obs_q[2][$];
  int obs_t[2][$];
  int abort_cnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(bit a, bit v, bit f, bit l, int lane, logic [7:0] d);
    logic [1:0] ln;
    ln = lane[1:0];
    return {18'b0, a, v, f, l, ln, d};
  endfunction

  function automatic logic [31:0] fld(logic [31:0] x, int lsb, int w);
    return (x >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] ob(int j, int i);
    if (i < obs_q[j].size()) return obs_q[j][i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int ot(int j, int i);
    if (i < obs_t[j].size()) return obs_t[j][i];
    return -1000;
  endfunction

  task automatic reset_model();
    for (int j = 0; j < 2; j++) begin
      owner[j] = -1; start[j] = 0; count[j] = 0; stall[j] = 0;
      e_vld[j] = 0; e_first[j] = 0; e_last[j] = 0; e_abort[j] = 0; e_lane[j] = 0; e_dat[j] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        src_q[j][i].delete();
        held[j][i] = 0;
        v_in[j][i] = 0;
        d_in[j][i] = 8'h00;
      end
    end
  endtask

  task automatic clear_obs();
    for (int j = 0; j < 2; j++) begin
      obs_q[j].delete();
      obs_t[j].delete();
    end
  endtask

  task automatic apply();
    bus_a.valid_in = {v_in[0][3], v_in[0][2], v_in[0][1], v_in[0][0]};
    bus_a.data_in  = {d_in[0][3], d_in[0][2], d_in[0][1], d_in[0][0]};
    bus_b.valid_in = {v_in[1][2], v_in[1][1], v_in[1][0]};
    bus_b.data_in  = {d_in[1][2], d_in[1][1], d_in[1][0]};
  endtask

  task automatic sample();
    o_vld[0] = bus_a.valid_out;  o_dat[0] = bus_a.data_out;  o_lane[0] = int'(bus_a.lane_out);
    o_first[0] = bus_a.first_out; o_last[0] = bus_a.last_out; o_abort[0] = bus_a.abort_out;
    o_rdy[0] = int'(bus_a.ready_out);
    o_vld[1] = bus_b.valid_out;  o_dat[1] = bus_b.data_out;  o_lane[1] = int'(bus_b.lane_out);
    o_first[1] = bus_b.first_out; o_last[1] = bus_b.last_out; o_abort[1] = bus_b.abort_out;
    o_rdy[1] = int'(bus_b.ready_out);
  endtask

  // A lane that has presented a byte keeps presenting it until accepted.
  task automatic drive_src(input int j);
    for (int i = 0; i < nl[j]; i++) begin
      if (src_q[j][i].size() > 0 && (held[j][i] || $urandom_range(99) < pct[j])) begin
        v_in[j][i] = 1;
        d_in[j][i] = src_q[j][i][0];
        held[j][i] = 1;
      end else begin
        v_in[j][i] = 0;
        d_in[j][i] = 8'($urandom);
      end
    end
  endtask

  task automatic step(input int j);
    int exp_rdy;
    bit found;
    exp_rdy = (owner[j] >= 0) ? (1 << owner[j]) : 0;
    chk($sformatf("ready%0d", j), o_rdy[j], exp_rdy);
    e_vld[j] = 0; e_first[j] = 0; e_last[j] = 0; e_abort[j] = 0; e_lane[j] = 0; e_dat[j] = 8'h00;
    if (owner[j] < 0) begin
      found = 0;
      for (int k = 0; k < nl[j]; k++) begin
        int l;
        l = (start[j] + k) % nl[j];
        if (!found && v_in[j][l]) begin
          found = 1; owner[j] = l; count[j] = 0; stall[j] = 0;
        end
      end
    end else if (v_in[j][owner[j]]) begin
      e_vld[j] = 1;
      e_dat[j] = d_in[j][owner[j]];
      e_lane[j] = owner[j];
      e_first[j] = (count[j] == 0);
      e_last[j] = (count[j] == 3);
      void'(src_q[j][owner[j]].pop_front());
      held[j][owner[j]] = 0;
      count[j]++;
      stall[j] = 0;
      if (count[j] == 4) begin
        start[j] = (owner[j] + 1) % nl[j];
        owner[j] = -1;
      end
    end else begin
      stall[j]++;
      if (stall[j] == to[j]) begin
        e_abort[j] = 1;
        start[j] = (owner[j] + 1) % nl[j];
        owner[j] = -1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_4f);
    cyc++;
    sample();
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("out%0d", j),
          pk(o_abort[j], o_vld[j], o_first[j], o_last[j], o_lane[j], o_dat[j]),
          pk(e_abort[j], e_vld[j], e_first[j], e_last[j], e_lane[j], e_dat[j]));
      if (o_vld[j] || o_abort[j]) begin
        obs_q[j].push_back(pk(o_abort[j], o_vld[j], o_first[j], o_last[j], o_lane[j], o_dat[j]));
        obs_t[j].push_back(cyc);
      end
      if (o_abort[j]) abort_cnt[j]++;
      drive_src(j);
    end
    apply();
    for (int j = 0; j < 2; j++) step(j);
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    reset_model();
    apply();
    cycle();
    cycle();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic push4(input int j, input int l, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    src_q[j][l].push_back(b0); src_q[j][l].push_back(b1);
    src_q[j][l].push_back(b2); src_q[j][l].push_back(b3);
  endtask

  task automatic run_obs(input int j, input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (obs_q[j].size() < n && k < bound) begin
      cycle();
      k++;
    end
    chk({tag, "_done"}, 32'(obs_q[j].size() >= n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_req;
    int k;
    pct[0] = 100; pct[1] = 100;
    abort_cnt[0] = 0; abort_cnt[1] = 0;
    reset = 1'b1;
    reset_model();
    apply();
    @(negedge clk_4f);
    sample();
    chk("rst_valid", 32'(o_vld[0]), 0);
    chk("rst_data", 32'(o_dat[0]), 0);
    chk("rst_lane", 32'(o_lane[0]), 0);
    chk("rst_first", 32'(o_first[0]), 0);
    chk("rst_last", 32'(o_last[0]), 0);
    chk("rst_abort", 32'(o_abort[0]), 0);
    chk("rst_ready", 32'(o_rdy[0]), 0);
    hard_reset();

    // Single word from lane 2, then ptr=3 decides between lanes 0 and 3.
    t_req = cyc + 1;
    push4(0, 2, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    run_obs(0, 4, 20, "single");
    chk("single_lat", 32'(ot(0, 0) - t_req), 2);
    chk("single_span", 32'(ot(0, 3) - ot(0, 0)), 3);
    chk("single_b0", ob(0, 0), pk(0, 1, 1, 0, 2, 8'hAA));
    chk("single_b3", ob(0, 3), pk(0, 1, 0, 1, 2, 8'hDD));
    push4(0, 0, 8'h01, 8'h02, 8'h03, 8'h04);
    push4(0, 3, 8'h31, 8'h32, 8'h33, 8'h34);
    run_obs(0, 12, 40, "ptr3");
    chk("ptr3_lane", fld(ob(0, 4), 8, 2), 3);
    chk("ptr3_next", fld(ob(0, 8), 8, 2), 0);

    // Fairness with every lane continuously valid.
    hard_reset();
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 8; b++) src_q[0][i].push_back(8'(i * 16 + b));
    run_obs(0, 20, 80, "fair");
    for (int w = 0; w < 5; w++) chk($sformatf("fair_w%0d", w), fld(ob(0, 4 * w), 8, 2), 32'(w % 4));
    chk("fair_gap", 32'(ot(0, 4) - ot(0, 3)), 2);
    chk("fair_w4_dat", fld(ob(0, 16), 0, 8), 32'h04);

    // Mid-word stall shorter than the timeout.
    hard_reset();
    src_q[0][1].push_back(8'h11); src_q[0][1].push_back(8'h22);
    k = 0;
    while (src_q[0][1].size() > 0 && k < 10) begin cycle(); k++; end
    repeat (5) cycle();
    src_q[0][1].push_back(8'h33); src_q[0][1].push_back(8'h44);
    run_obs(0, 4, 20, "stall");
    repeat (3) cycle();
    chk("stall_cnt", 32'(obs_q[0].size()), 4);
    chk("stall_b2", ob(0, 2), pk(0, 1, 0, 0, 1, 8'h33));
    chk("stall_b3", ob(0, 3), pk(0, 1, 0, 1, 1, 8'h44));

    // Timeout after a single byte; lane 1 waits and gets the next grant.
    hard_reset();
    src_q[0][0].push_back(8'h5A);
    push4(0, 1, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    run_obs(0, 3, 60, "tmo");
    chk("tmo_first", ob(0, 0), pk(0, 1, 1, 0, 0, 8'h5A));
    chk("tmo_abort", ob(0, 1), pk(1, 0, 0, 0, 0, 8'h00));
    chk("tmo_dist", 32'(ot(0, 1) - ot(0, 0)), 15);
    chk("tmo_next", ob(0, 2), pk(0, 1, 1, 0, 1, 8'hA1));

    // Asynchronous reset in the middle of a word.
    hard_reset();
    push4(0, 2, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    run_obs(0, 2, 20, "arst");
    #2;
    reset = 1'b1;
    #1;
    sample();
    chk("arst_valid", 32'(o_vld[0]), 0);
    chk("arst_data", 32'(o_dat[0]), 0);
    chk("arst_ready", 32'(o_rdy[0]), 0);
    chk("arst_abort", 32'(o_abort[0]), 0);
    reset_model();
    apply();
    cycle();
    reset = 1'b0;
    clear_obs();
    push4(0, 3, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    push4(0, 0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    run_obs(0, 1, 10, "arst_rel");
    chk("arst_win", fld(ob(0, 0), 8, 2), 0);

    // Wrap-around on the 3-lane instance.
    hard_reset();
    push4(1, 1, 8'h71, 8'h72, 8'h73, 8'h74);
    run_obs(1, 4, 20, "wrap_pre");
    push4(1, 2, 8'h81, 8'h82, 8'h83, 8'h84);
    push4(1, 0, 8'h91, 8'h92, 8'h93, 8'h94);
    run_obs(1, 12, 40, "wrap");
    chk("wrap_w1", fld(ob(1, 4), 8, 2), 2);
    chk("wrap_w2", fld(ob(1, 8), 8, 2), 0);
    push4(1, 0, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    push4(1, 1, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
    run_obs(1, 16, 40, "wrap_ptr");
    chk("wrap_ptr1", fld(ob(1, 12), 8, 2), 1);

    // Random traffic with bursty, sometimes starving sources.
    hard_reset();
    abort_cnt[0] = 0; abort_cnt[1] = 0;
    pct[0] = 75; pct[1] = 65;
    for (int c = 0; c < 4000; c++) begin
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < nl[j]; i++)
          if (src_q[j][i].size() == 0 && $urandom_range(99) < 8)
            repeat ($urandom_range(6, 1)) src_q[j][i].push_back(8'($urandom));
      if (c % 500 == 0) clear_obs();
      cycle();
    end
    repeat (100) cycle();
    chk("rnd_aborts_b", 32'(abort_cnt[1] > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_lane_arbiter_4f.md
# byte_lane_arbiter_4f

Round-robin scheduler that shares the single 8-bit→32-bit word packer among NLANES byte-stream lanes on the clk_4f domain. It grants one lane at a time for exactly one 4-byte word, so bytes from different lanes are never interleaved inside a packed word. It forwards the granted lane's bytes to the packer with first/last markers and a lane tag. It aborts a word whose source stalls too long.

## Interface
- NLANES, 4: number of requesting lanes; 2..4, lane index width 2 bits.
- TIMEOUT, 15: consecutive no-transfer cycles tolerated inside a granted word before abort; 1..255.

- clk_4f  in  1  packer clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid_in  in  NLANES  per-lane byte valid.
- data_in  in  8*NLANES  lane i byte at [8i+7:8i].
- ready_out  out  NLANES  per-lane accept; combinational from registered state only.
- valid_out  out  1  byte valid toward packer, registered.
- data_out  out  8  forwarded byte, registered.
- lane_out  out  2  source lane of data_out, registered.
- first_out  out  1  byte 0 of a word, qualified by valid_out.
- last_out  out  1  byte 3 of a word, qualified by valid_out.
- abort_out  out  1  one-cycle pulse: current word discarded.

## Operation
- States: IDLE, BURST. Registers: grant[1:0], ptr[1:0] (round-robin start), bcnt[1:0] (bytes transferred in word), icnt[7:0] (idle counter).
- IDLE: if any valid_in set, select first set lane scanning ptr, ptr+1, … modulo NLANES. grant <= that lane, bcnt <= 0, icnt <= 0, go BURST. Otherwise stay.
- BURST: ready_out[grant] = 1, all other ready_out = 0. In IDLE all ready_out = 0.
- Transfer = valid_in[grant] && ready_out[grant]. On a transfer, next cycle: valid_out=1, data_out=byte, lane_out=grant, first_out=(bcnt==0), last_out=(bcnt==3). bcnt increments, icnt <= 0.
- Transfer with bcnt==3: go IDLE, ptr <= grant+1, wrapping at NLANES.
- BURST cycle with no transfer: icnt increments. When icnt reaches TIMEOUT-1 on a non-transfer cycle, the next cycle has abort_out=1 and valid_out=0; go IDLE, ptr <= grant+1. Bytes already forwarded are discarded by the packer on abort.
- Non-granted lanes' valid_in is ignored and never lost. Lanes hold data until ready_out.
- Outputs not named above are 0 in any cycle without a transfer or abort.

## Timing
- Reset values: valid_out=0, data_out=8'h00, lane_out=0, first_out=0, last_out=0, abort_out=0, ready_out=0. State=IDLE, ptr=0, bcnt=0, icnt=0.
- Reset mid-word: the partial word is dropped silently, with no abort pulse. After reset releases, arbitration restarts at lane 0.
- Request latency: valid_in rising in IDLE at cycle n gives ready_out at n+1. The first transfer occurs at n+1, and valid_out/first_out appear at n+2.
- Sustained throughput with all lanes continuously valid is 4 bytes per 5 cycles, because one IDLE arbitration cycle follows each word.
- Simultaneous last-byte transfer and a new request on another lane: the new request is arbitrated in the following IDLE cycle using the updated ptr.
- Abort fires exactly TIMEOUT stalled cycles after the last transfer, or after grant if no byte has transferred yet.

## Structure
- Shared package: state encoding (IDLE=0, BURST=1), LANE_W=2, BYTES_PER_WORD=4 constant.
- Sub-module rr_pick: combinational. Takes req[NLANES-1:0] and ptr; produces gnt_idx and any_req.
- The top block contains the FSM, counters and output registers.

## Test plan
- Single word: lane 2 presents bytes AA,BB,CC,DD continuously from idle → valid_out for 4 cycles starting 2 cycles later, lane_out=2, first_out on AA, last_out on DD, ptr=3.
- Fairness: all 4 lanes valid continuously, with lane i sending byte 8'hi0+k → words emitted in lane order 0,1,2,3,0. There is never a mixed-lane word, and there is a 1-cycle valid_out gap between words.
- Mid-word stall: lane 1 sends 11,22, drops valid for 5 cycles, then sends 33,44 (TIMEOUT=15) → one complete word 11,22,33,44 with no abort.
- Timeout: lane 0 sends one byte 5A then goes silent (TIMEOUT=15) → abort_out pulses exactly 15 cycles after the 5A transfer cycle, and the next grant goes to lane 1 if it is requesting.
- Async reset mid-word: assert reset between clock edges after 2 bytes → all outputs are 0 immediately with no abort pulse. After release, lane 3 and lane 0 both request, and lane 0 wins.
- Wrap-around with NLANES=3: lanes 2 and 0 requesting, ptr=2 → lane 2 is served, then lane 0, then ptr=1.
